// File: rtl/temp_avg_engine.sv
// Averages up to eight 8-bit sensor readings.
// One reading is accumulated per cycle, then a 16-step restoring divide yields the quotient and remainder.
module temp_avg_engine (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [63:0] sensors_data_i,
  input  logic [7:0]  sensors_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] temp_Q_o,
  output logic [15:0] temp_R_o,
  output logic [7:0]  active_sensors_nr_o,
  output logic        div_zero_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] data_q;
  logic [7:0]  en_q;
  logic [3:0]  step;
  logic [10:0] sum;
  logic [3:0]  count;
  logic [15:0] quo;
  logic [15:0] rem;

  logic [7:0]  reading;
  logic        sel;
  logic [10:0] sum_next;
  logic [3:0]  count_next;
  logic [15:0] divisor;
  logic [15:0] rem_shift;
  logic        fits;
  logic [15:0] rem_step;
  logic [15:0] quo_step;

  // Accumulate and divide-step datapath, shared by the FSM and the register update.
  always_comb begin
    reading    = data_q[{step[2:0], 3'b000} +: 8];
    sel        = en_q[step[2:0]];
    sum_next   = sum + (sel ? {3'b000, reading} : 11'd0);
    count_next = count + {3'b000, sel};
    divisor    = {12'd0, count};
    rem_shift  = {rem[14:0], quo[15]};
    fits       = (rem_shift >= divisor);
    rem_step   = fits ? (rem_shift - divisor) : rem_shift;
    quo_step   = {quo[14:0], fits};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    busy_o     = (state != IDLE);
    done_o     = (state == DONE);
    case (state)
      IDLE:   if (start_i) state_next = ACCUM;
      ACCUM:  if (step[2:0] == 3'd7) state_next = (count_next != 4'd0) ? DIVIDE : DONE;
      DIVIDE: if (step == 4'd15) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the reset clears every register
  // so an aborted pass leaves no trace on the outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q              <= '0;
      en_q                <= '0;
      step                <= '0;
      sum                 <= '0;
      count               <= '0;
      quo                 <= '0;
      rem                 <= '0;
      temp_Q_o            <= '0;
      temp_R_o            <= '0;
      active_sensors_nr_o <= '0;
      div_zero_o          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            data_q <= sensors_data_i;
            en_q   <= sensors_en_i;
            sum    <= '0;
            count  <= '0;
            step   <= '0;
          end
        end
        ACCUM: begin
          sum   <= sum_next;
          count <= count_next;
          if (step[2:0] == 3'd7) begin
            step <= '0;
            quo  <= {5'd0, sum_next};
            rem  <= '0;
            if (count_next == 4'd0) begin
              temp_Q_o            <= '0;
              temp_R_o            <= '0;
              active_sensors_nr_o <= '0;
              div_zero_o          <= 1'b1;
            end
          end else begin
            step <= step + 4'd1;
          end
        end
        DIVIDE: begin
          quo  <= quo_step;
          rem  <= rem_step;
          step <= step + 4'd1;
          // Results land together with the final quotient bit, never mid-divide.
          if (step == 4'd15) begin
            temp_Q_o            <= quo_step;
            temp_R_o            <= rem_step;
            active_sensors_nr_o <= {4'd0, count};
            div_zero_o          <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_avg_engine.sv
// Self-checking bench for temp_avg_engine: directed literal cases plus randomized traffic
// compared every cycle against a latency/arithmetic reference model.
module tb_temp_avg_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] data;
  logic [7:0]  en;
  logic        busy_o;
  logic        done_o;
  logic [15:0] temp_Q_o;
  logic [15:0] temp_R_o;
  logic [7:0]  active_sensors_nr_o;
  logic        div_zero_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  temp_avg_engine dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start),
    .sensors_data_i      (data),
    .sensors_en_i        (en),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .temp_Q_o            (temp_Q_o),
    .temp_R_o            (temp_R_o),
    .active_sensors_nr_o (active_sensors_nr_o),
    .div_zero_o          (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  nr;
    logic        dz;
    int          lat;
  } result_t;

  // Average of the enabled readings, straight from the arithmetic definition.
  function automatic result_t reference(input logic [63:0] d, input logic [7:0] e);
    result_t res;
    int s = 0;
    int n = 0;
    for (int j = 0; j < 8; j++) begin
      if (e[j]) begin
        s += int'(d[8*j +: 8]);
        n++;
      end
    end
    if (n == 0) begin
      res.q = 0; res.r = 0; res.nr = 0; res.dz = 1'b1; res.lat = 8;
    end else begin
      res.q = 16'(s / n); res.r = 16'(s % n); res.nr = 8'(n); res.dz = 1'b0; res.lat = 24;
    end
    return res;
  endfunction

  // Model: a pass accepted at edge k finishes L edges later; outputs switch at edge k+L.
  int          remaining   = 0;
  bit          model_valid = 0;
  result_t     pend;
  logic [15:0] m_q, m_r;
  logic [7:0]  m_nr;
  logic        m_dz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      remaining   <= 0;
      m_q <= 0; m_r <= 0; m_nr <= 0; m_dz <= 0;
      model_valid <= 1;
    end else if (remaining == 0) begin
      if (start) begin
        pend      <= reference(data, en);
        remaining <= reference(data, en).lat + 1;
      end
    end else begin
      remaining <= remaining - 1;
      if (remaining == 2) begin
        m_q <= pend.q; m_r <= pend.r; m_nr <= pend.nr; m_dz <= pend.dz;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("busy", busy_o, remaining > 0);
      check("done", done_o, remaining == 1);
      check("temp_q", temp_Q_o, m_q);
      check("temp_r", temp_R_o, m_r);
      check("nr", active_sensors_nr_o, m_nr);
      check("div_zero", div_zero_o, m_dz);
    end
  end

  task automatic run_pass(input string name, input logic [63:0] d, input logic [7:0] e,
                          input logic [15:0] eq, input logic [15:0] er, input logic [7:0] enr,
                          input logic edz, input int elat);
    int k;
    bit seen = 0;
    @(negedge clk); start = 1; data = d; en = e;
    @(negedge clk); start = 0; k = cyc;
    data = {$urandom, $urandom}; en = 8'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_o) seen = 1;
      else @(negedge clk);
    end
    check({name, "_done_seen"}, seen, 1);
    if (seen) begin
      check({name, "_latency"}, cyc - k, elat);
      check({name, "_q"}, temp_Q_o, eq);
      check({name, "_r"}, temp_R_o, er);
      check({name, "_nr"}, active_sensors_nr_o, enr);
      check({name, "_dz"}, div_zero_o, edz);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int dones;
    logic [15:0] q_seen;
    logic [15:0] r_seen;
    rst_n = 0; start = 0; data = '0; en = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_q", temp_Q_o, 0);
    check("rst_dz", div_zero_o, 0);
    rst_n = 1;
    @(negedge clk);

    run_pass("all25", {8{8'd25}}, 8'hFF, 16'd25, 16'd0, 8'd8, 1'b0, 24);
    run_pass("two", {{6{8'hFF}}, 8'd21, 8'd20}, 8'h03, 16'd20, 16'd1, 8'd2, 1'b0, 24);
    run_pass("three", {{5{8'hFF}}, 8'd22, 8'd21, 8'd20}, 8'h07, 16'd21, 16'd0, 8'd3, 1'b0, 24);
    run_pass("none", {8{8'd77}}, 8'h00, 16'd0, 16'd0, 8'd0, 1'b1, 8);
    run_pass("all255", {8{8'd255}}, 8'hFF, 16'd255, 16'd0, 8'd8, 1'b0, 24);
    run_pass("s7only", {8'd200, {7{8'd255}}}, 8'h80, 16'd200, 16'd0, 8'd1, 1'b0, 24);

    // Extra start during DIVIDE with changed inputs: exactly one done, original results.
    @(negedge clk); start = 1; data = {32'd0, 8'd41, 8'd30, 8'd20, 8'd10}; en = 8'h0F;
    @(negedge clk); start = 0; k = cyc; data = {8{8'd3}}; en = 8'hFF;
    dones = 0; q_seen = 0; r_seen = 0;
    for (int i = 0; i < 50; i++) begin
      start = (cyc - k == 12);
      if (done_o) begin dones++; q_seen = temp_Q_o; r_seen = temp_R_o; end
      @(negedge clk);
    end
    start = 0;
    check("restart_done_count", dones, 1);
    check("restart_q", q_seen, 16'd25);
    check("restart_r", r_seen, 16'd1);

    // Reset for one edge at k+15 aborts the pass.
    @(negedge clk); start = 1; data = {8{8'd100}}; en = 8'hFF;
    @(negedge clk); start = 0; k = cyc;
    while (cyc - k < 14) @(negedge clk);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_q", temp_Q_o, 0);
    check("abort_nr", active_sensors_nr_o, 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    run_pass("after_abort", {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2}, 8'hFF,
             16'd5, 16'd4, 8'd8, 1'b0, 24);

    // Randomized traffic: start attempts in every state, occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      data  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       en = 8'h00;
        1:       en = 8'hFF;
        default: en = 8'($urandom);
      endcase
      rst_n = !($urandom_range(0, 399) == 0);
    end
    @(negedge clk); start = 0; rst_n = 1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
